// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor
//   Fetch-stage branch predictor. It combines an N-way set-associative BTB
//   (round-robin replacement) with a gshare direction table of saturating
//   counters. The table is indexed by PC XOR a speculative global history
//   register. Lookups are registered with one cycle of latency. A single
//   resolve port trains the tables and restores history on a mispredict.
//
// Ports
//   clk, resetn     clock, synchronous active-low reset
//   req_vld/req_pc  lookup request (accepted every cycle, no backpressure)
//   rsp_*           registered lookup result: pc, hit, one-hot way,
//                   predicted direction, next pc, and the history used
//   upd_*           resolved branch: pc, direction, target, way vector and
//                   history from its lookup, and a mispredict flag
//
// Handshake: there is no ready. A request presented with req_vld=1 at an edge
// always produces rsp_vld=1 for exactly the following cycle. With req_vld=0,
// rsp_vld drops to 0 and the other rsp_* fields keep their last value. An
// update presented with upd_vld=1 is consumed at that same edge.
module gshare_btb_predictor #(
    parameter int WAYS      = 2,
    parameter int SET_W     = 6,
    parameter int GHR_W     = 8,
    parameter int PHT_IDX_W = 10,
    parameter int CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_vld,
    input  logic [31:0]          req_pc,
    output logic                 rsp_vld,
    output logic [31:0]          rsp_pc,
    output logic                 rsp_hit,
    output logic [WAYS-1:0]      rsp_way_vec,
    output logic                 rsp_taken,
    output logic [31:0]          rsp_next_pc,
    output logic [GHR_W-1:0]     rsp_ghr,
    input  logic                 upd_vld,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target,
    input  logic [WAYS-1:0]      upd_way_vec,
    input  logic [GHR_W-1:0]     upd_ghr,
    input  logic                 upd_mispredict
);
    localparam int SETS  = 1 << SET_W;
    localparam int TAG_W = 30 - SET_W;
    localparam int PHT_N = 1 << PHT_IDX_W;
    localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};

    logic               r_valid  [SETS][WAYS];
    logic [TAG_W-1:0]   r_tag    [SETS][WAYS];
    logic [29:0]        r_target [SETS][WAYS];
    logic [CNT_W-1:0]   r_pht    [PHT_N];
    logic [RR_W-1:0]    r_rr     [SETS];
    logic [GHR_W-1:0]   r_ghr;

    // ---------------- lookup path ----------------
    logic [SET_W-1:0]     w_req_set;
    logic [TAG_W-1:0]     w_req_tag;
    logic [PHT_IDX_W-1:0] w_req_idx;
    logic [WAYS-1:0]      w_hit_vec;
    logic                 w_hit;
    logic [29:0]          w_hit_tgt;
    logic                 w_taken;
    logic [31:0]          w_next_pc;

    assign w_req_set = req_pc[SET_W+1:2];
    assign w_req_tag = req_pc[31:SET_W+2];
    assign w_req_idx = req_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(r_ghr);

    // Scanned from the top way down so that the lowest matching way wins.
    always_comb begin
        w_hit_vec = '0;
        w_hit     = 1'b0;
        w_hit_tgt = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_req_set][w] && (r_tag[w_req_set][w] == w_req_tag)) begin
                w_hit_vec    = '0;
                w_hit_vec[w] = 1'b1;
                w_hit        = 1'b1;
                w_hit_tgt    = r_target[w_req_set][w];
            end
        end
    end

    assign w_taken   = w_hit & r_pht[w_req_idx][CNT_W-1];
    assign w_next_pc = w_taken ? {w_hit_tgt, 2'b00} : (req_pc + 32'd4);

    // ---------------- update path ----------------
    logic [SET_W-1:0]     w_upd_set;
    logic [PHT_IDX_W-1:0] w_upd_idx;
    logic [CNT_W-1:0]     w_cnt_cur;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_btb_wr;
    logic [RR_W-1:0]      w_upd_way;
    logic                 w_rr_adv;
    logic [RR_W-1:0]      w_rr_nxt;
    logic                 w_unused_bits;

    assign w_upd_set = upd_pc[SET_W+1:2];
    assign w_upd_idx = upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_ghr);
    assign w_cnt_cur = r_pht[w_upd_idx];
    assign w_btb_wr  = upd_vld & upd_taken;

    // Instruction alignment bits carry no information here.
    assign w_unused_bits = ^{upd_pc[1:0], upd_target[1:0]};

    always_comb begin
        w_cnt_nxt = w_cnt_cur;
        if (upd_taken) begin
            if (w_cnt_cur != {CNT_W{1'b1}}) w_cnt_nxt = w_cnt_cur + CNT_W'(1);
        end else begin
            if (w_cnt_cur != '0) w_cnt_nxt = w_cnt_cur - CNT_W'(1);
        end
    end

    // Way choice: the way the lookup hit if there was one, otherwise the lowest
    // invalid way, otherwise the round-robin victim (which then advances).
    always_comb begin
        w_upd_way = '0;
        w_rr_adv  = 1'b0;
        if (upd_way_vec != '0) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (upd_way_vec[w]) w_upd_way = RR_W'(w);
            end
        end else begin
            w_upd_way = r_rr[w_upd_set];
            w_rr_adv  = 1'b1;
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (!r_valid[w_upd_set][w]) begin
                    w_upd_way = RR_W'(w);
                    w_rr_adv  = 1'b0;
                end
            end
        end
    end

    assign w_rr_nxt = (r_rr[w_upd_set] == RR_W'(WAYS - 1)) ? '0
                                                           : r_rr[w_upd_set] + RR_W'(1);

    // ---------------- state with reset ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
                for (int w = 0; w < WAYS; w++) r_valid[s][w] <= 1'b0;
            end
            for (int i = 0; i < PHT_N; i++) r_pht[i] <= CNT_INIT;
            r_ghr       <= '0;
            rsp_vld     <= 1'b0;
            rsp_pc      <= '0;
            rsp_hit     <= 1'b0;
            rsp_way_vec <= '0;
            rsp_taken   <= 1'b0;
            rsp_next_pc <= '0;
            rsp_ghr     <= '0;
        end else begin
            rsp_vld <= req_vld;
            if (req_vld) begin
                rsp_pc      <= req_pc;
                rsp_hit     <= w_hit;
                rsp_way_vec <= w_hit_vec;
                rsp_taken   <= w_taken;
                rsp_next_pc <= w_next_pc;
                rsp_ghr     <= r_ghr;
            end

            // A mispredict restore overrides the speculative shift.
            if (upd_vld && upd_mispredict)
                r_ghr <= {upd_ghr[GHR_W-2:0], upd_taken};
            else if (req_vld && w_hit)
                r_ghr <= {r_ghr[GHR_W-2:0], w_taken};

            if (upd_vld) r_pht[w_upd_idx] <= w_cnt_nxt;

            if (w_btb_wr) begin
                r_valid[w_upd_set][w_upd_way] <= 1'b1;
                if (w_rr_adv) r_rr[w_upd_set] <= w_rr_nxt;
            end
        end
    end

    // Tag and target need no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (resetn && w_btb_wr) begin
            r_tag[w_upd_set][w_upd_way]    <= upd_pc[31:SET_W+2];
            r_target[w_upd_set][w_upd_way] <= upd_target[31:2];
        end
    end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
module tb_gshare_btb_predictor;
    localparam int WAYS      = 2;
    localparam int SET_W     = 6;
    localparam int GHR_W     = 8;
    localparam int PHT_IDX_W = 10;
    localparam int CNT_W     = 2;
    localparam int RSP_W     = 76;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             req_vld = 1'b0;
    logic [31:0]      req_pc = '0;
    logic             rsp_vld;
    logic [31:0]      rsp_pc;
    logic             rsp_hit;
    logic [WAYS-1:0]  rsp_way_vec;
    logic             rsp_taken;
    logic [31:0]      rsp_next_pc;
    logic [GHR_W-1:0] rsp_ghr;
    logic             upd_vld = 1'b0;
    logic [31:0]      upd_pc = '0;
    logic             upd_taken = 1'b0;
    logic [31:0]      upd_target = '0;
    logic [WAYS-1:0]  upd_way_vec = '0;
    logic [GHR_W-1:0] upd_ghr = '0;
    logic             upd_mispredict = 1'b0;

    gshare_btb_predictor #(
        .WAYS(WAYS), .SET_W(SET_W), .GHR_W(GHR_W), .PHT_IDX_W(PHT_IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_vld(req_vld), .req_pc(req_pc),
        .rsp_vld(rsp_vld), .rsp_pc(rsp_pc), .rsp_hit(rsp_hit),
        .rsp_way_vec(rsp_way_vec), .rsp_taken(rsp_taken),
        .rsp_next_pc(rsp_next_pc), .rsp_ghr(rsp_ghr),
        .upd_vld(upd_vld), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_way_vec(upd_way_vec),
        .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [RSP_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid [64][2];
    logic [23:0] m_tag   [64][2];
    logic [31:0] m_tgt   [64][2];
    int          m_pht   [1024];
    int          m_rr    [64];
    logic [7:0]  m_ghr;

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
        end
        for (int i = 0; i < 1024; i++) m_pht[i] = 1;
        m_ghr = 8'h00;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output bit hit, output int way, output bit tk);
        logic [5:0] set;
        logic [9:0] idx;
        set = pc[7:2];
        hit = 1'b0;
        way = 0;
        for (int w = 0; w < 2; w++) begin
            if (!hit && m_valid[set][w] && m_tag[set][w] == pc[31:8]) begin
                hit = 1'b1;
                way = w;
            end
        end
        idx = pc[11:2] ^ {2'b00, m_ghr};
        tk  = hit && (m_pht[idx] >= 2);
    endtask

    // ---------------- driver ----------------
    // One call = one clock cycle of inputs; the model advances in step and
    // any request's expected response is queued.
    task automatic drive(input bit rn, input bit rq, input logic [31:0] pc,
                         input bit up, input logic [31:0] upc, input bit tk,
                         input logic [31:0] tgt, input logic [1:0] wv,
                         input logic [7:0] g, input bit mis);
        bit          hit;
        int          way;
        bit          ptk;
        int          w;
        logic [1:0]  evec;
        logic [31:0] enext;
        logic [5:0]  us;
        logic [9:0]  ui;
        @(negedge clk);
        resetn = rn; req_vld = rq; req_pc = pc;
        upd_vld = up; upd_pc = upc; upd_taken = tk; upd_target = tgt;
        upd_way_vec = wv; upd_ghr = g; upd_mispredict = mis;
        model_lookup(pc, hit, way, ptk);
        if (!rn) begin
            model_reset();
        end else begin
            if (rq) begin
                evec  = hit ? ((way == 0) ? 2'b01 : 2'b10) : 2'b00;
                enext = ptk ? m_tgt[pc[7:2]][way] : pc + 32'd4;
                exp_q.push_back({pc, hit, evec, ptk, enext, m_ghr});
            end
            if (up && mis)
                m_ghr = {g[6:0], tk};
            else if (rq && hit)
                m_ghr = {m_ghr[6:0], ptk};
            if (up) begin
                ui = upc[11:2] ^ {2'b00, g};
                if (tk) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
                else    m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
            end
            if (up && tk) begin
                us = upc[7:2];
                if (wv != 2'b00)          w = wv[0] ? 0 : 1;
                else if (!m_valid[us][0]) w = 0;
                else if (!m_valid[us][1]) w = 1;
                else begin
                    w = m_rr[us];
                    m_rr[us] = (m_rr[us] + 1) % 2;
                end
                m_valid[us][w] = 1'b1;
                m_tag[us][w]   = upc[31:8];
                m_tgt[us][w]   = {tgt[31:2], 2'b00};
            end
        end
    endtask

    task automatic idle();
        drive(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 2'b00, 8'h00, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 2'b00, 8'h00, 0);
        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 2'b00, 8'h00, 0);
    endtask

    task automatic do_req(input logic [31:0] pc);
        drive(1, 1, pc, 0, 32'h0, 0, 32'h0, 2'b00, 8'h00, 0);
    endtask

    task automatic do_upd(input logic [31:0] upc, input bit tk, input logic [31:0] tgt,
                          input logic [1:0] wv, input logic [7:0] g, input bit mis);
        drive(1, 0, 32'h0, 1, upc, tk, tgt, wv, g, mis);
    endtask

    task automatic do_both(input logic [31:0] pc, input logic [31:0] upc, input bit tk,
                           input logic [31:0] tgt, input logic [1:0] wv,
                           input logic [7:0] g, input bit mis);
        drive(1, 1, pc, 1, upc, tk, tgt, wv, g, mis);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [RSP_W-1:0] e;
        if (rsp_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {31'b0, rsp_vld}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_pc",      rsp_pc,              e[75:44]);
                check("rsp_hit",     {31'b0, rsp_hit},    {31'b0, e[43]});
                check("rsp_way_vec", {30'b0, rsp_way_vec}, {30'b0, e[42:41]});
                check("rsp_taken",   {31'b0, rsp_taken},  {31'b0, e[40]});
                check("rsp_next_pc", rsp_next_pc,         e[39:8]);
                check("rsp_ghr",     {24'b0, rsp_ghr},    {24'b0, e[7:0]});
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pc, upc, tgt;
        bit          rq, up, tk, mis, hit, ptk;
        int          way;
        logic [1:0]  wv;
        logic [7:0]  g;

        model_reset();

        // Reset state
        do_reset();
        check("rst_vld",  {31'b0, rsp_vld},  32'd0);
        check("rst_hit",  {31'b0, rsp_hit},  32'd0);
        check("rst_taken",{31'b0, rsp_taken},32'd0);
        check("rst_way",  {30'b0, rsp_way_vec}, 32'd0);
        check("rst_pc",   rsp_pc,      32'd0);
        check("rst_next", rsp_next_pc, 32'd0);
        check("rst_ghr",  {24'b0, rsp_ghr}, 32'd0);

        // Cold lookup misses
        do_req(32'h1000); idle();
        check("t1_vld",  {31'b0, rsp_vld}, 32'd1);
        check("t1_hit",  {31'b0, rsp_hit}, 32'd0);
        check("t1_next", rsp_next_pc, 32'h1004);
        check("t1_ghr",  {24'b0, rsp_ghr}, 32'd0);
        idle();
        check("t1_vld_one_cycle", {31'b0, rsp_vld}, 32'd0);
        check("t1_hold_next", rsp_next_pc, 32'h1004);
        do_req(32'h1000); idle();
        check("t1_ghr_no_shift", {24'b0, rsp_ghr}, 32'd0);

        // Allocate then hit
        do_reset();
        do_upd(32'h1000, 1, 32'h2000, 2'b00, 8'h00, 0);
        do_req(32'h1000); idle();
        check("t2_hit",   {31'b0, rsp_hit},   32'd1);
        check("t2_way",   {30'b0, rsp_way_vec}, 32'd1);
        check("t2_taken", {31'b0, rsp_taken}, 32'd1);
        check("t2_next",  rsp_next_pc, 32'h2000);
        do_req(32'h1000); idle();
        check("t2_ghr_shift", {24'b0, rsp_ghr}, 32'h01);

        // Replacement in a full set
        do_reset();
        do_upd(32'h1000, 1, 32'h1100, 2'b00, 8'h00, 0);
        do_upd(32'h2000, 1, 32'h2200, 2'b00, 8'h00, 0);
        do_upd(32'h3000, 1, 32'h3300, 2'b00, 8'h00, 0);
        do_req(32'h1000); idle();
        check("t3_evicted_miss", {31'b0, rsp_hit}, 32'd0);
        do_req(32'h3000); idle();
        check("t3_repl_way",  {30'b0, rsp_way_vec}, 32'd1);
        check("t3_repl_next", rsp_next_pc, 32'h3300);
        do_req(32'h2000); idle();
        check("t3_keep_way",  {30'b0, rsp_way_vec}, 32'd2);
        do_upd(32'h1000, 1, 32'h1100, 2'b00, 8'h00, 0);
        do_req(32'h1000); idle();
        check("t3_rr_adv_way", {30'b0, rsp_way_vec}, 32'd2);
        do_req(32'h2000); idle();
        check("t3_rr_evict", {31'b0, rsp_hit}, 32'd0);

        // Counter saturation
        do_reset();
        do_upd(32'h1000, 1, 32'h2000, 2'b00, 8'h00, 0);
        do_upd(32'h1000, 1, 32'h2000, 2'b01, 8'h00, 0);
        do_upd(32'h1000, 1, 32'h2000, 2'b01, 8'h00, 0);
        do_upd(32'h1000, 1, 32'h2000, 2'b01, 8'h00, 0);
        do_upd(32'h1000, 0, 32'h0,    2'b01, 8'h00, 0);
        do_req(32'h1000); idle();
        check("t4_sat_taken", {31'b0, rsp_taken}, 32'd1);
        check("t4_sat_next",  rsp_next_pc, 32'h2000);

        // Mispredict restore
        do_reset();
        do_upd(32'h1000, 1, 32'h2000, 2'b00, 8'h00, 0);
        do_req(32'h1000);
        do_upd(32'h1000, 0, 32'h0, 2'b01, 8'h5A, 1);
        do_req(32'h2000); idle();
        check("t5_restore_ghr", {24'b0, rsp_ghr}, 32'hB4);
        do_reset();
        do_upd(32'h1000, 1, 32'h2000, 2'b00, 8'h00, 0);
        do_req(32'h1000);
        do_both(32'h1000, 32'h1000, 0, 32'h0, 2'b01, 8'h5A, 1);
        idle();
        check("t5_same_cycle_hit", {31'b0, rsp_hit}, 32'd1);
        check("t5_same_cycle_ghr", {24'b0, rsp_ghr}, 32'h01);
        do_req(32'h2000); idle();
        check("t5_restore_wins", {24'b0, rsp_ghr}, 32'hB4);

        // Same-cycle lookup and target rewrite
        do_reset();
        do_upd(32'h1000, 1, 32'h2000, 2'b00, 8'h00, 0);
        do_upd(32'h1000, 1, 32'h2000, 2'b01, 8'h01, 0);
        do_both(32'h1000, 32'h1000, 1, 32'h4000, 2'b01, 8'h00, 0);
        idle();
        check("t6_old_target", rsp_next_pc, 32'h2000);
        do_req(32'h1000); idle();
        check("t6_new_target", rsp_next_pc, 32'h4000);

        // Reset in the middle of traffic drops the in-flight request and update
        do_req(32'h1000);
        drive(0, 1, 32'h1000, 1, 32'h1000, 1, 32'h5000, 2'b01, 8'h00, 0);
        idle();
        check("mid_rst_vld",  {31'b0, rsp_vld},  32'd0);
        check("mid_rst_hit",  {31'b0, rsp_hit},  32'd0);
        check("mid_rst_next", rsp_next_pc, 32'd0);
        check("mid_rst_pc",   rsp_pc,      32'd0);
        do_req(32'h1000); idle();
        check("mid_rst_cleared", {31'b0, rsp_hit}, 32'd0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            rq  = bit'($urandom_range(0, 1));
            up  = ($urandom_range(0, 2) == 0);
            tk  = bit'($urandom_range(0, 1));
            mis = ($urandom_range(0, 3) == 0);
            pc  = 32'h1000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 1)) << 2);
            upc = 32'h1000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 1)) << 2);
            tgt = $urandom();
            g   = 8'($urandom_range(0, 255));
            model_lookup(upc, hit, way, ptk);
            wv  = hit ? ((way == 0) ? 2'b01 : 2'b10) : 2'b00;
            drive(1, rq, pc, up, upc, tk, tgt, wv, g, mis);
        end
        idle();
        idle();
        idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gshare_btb_predictor.md
Name: gshare_btb_predictor

Overview:
Second-generation fetch-stage branch predictor. It combines an N-way set-associative BTB with round-robin replacement and a gshare direction table indexed by PC XOR a speculative global history register (GHR), and it restores history on mispredict. Lookup is registered with one-cycle latency and produces the predicted next PC. The backend drives a single resolve/update port.

Parameters:
WAYS, 2, BTB associativity (1..8)
SET_W, 6, log2 BTB sets; set index = pc[SET_W+1:2], tag = pc[31:SET_W+2]
GHR_W, 8, global history bits; must be <= PHT_IDX_W
PHT_IDX_W, 10, log2 PHT entries
CNT_W, 2, saturating counter width (>=2)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
req_vld  in  1  lookup request
req_pc  in  32  fetch PC
rsp_vld  out  1  response valid, one cycle after req_vld
rsp_pc  out  32  PC of response
rsp_hit  out  1  BTB hit
rsp_way_vec  out  WAYS  one-hot hit way, 0 on miss
rsp_taken  out  1  predicted taken
rsp_next_pc  out  32  target if taken, else rsp_pc+4
rsp_ghr  out  GHR_W  GHR value used for this lookup
upd_vld  in  1  resolved branch update
upd_pc  in  32  branch PC
upd_taken  in  1  actual direction
upd_target  in  32  actual target (bits [1:0] ignored)
upd_way_vec  in  WAYS  rsp_way_vec from the lookup; 0 = was a miss
upd_ghr  in  GHR_W  rsp_ghr from the lookup
upd_mispredict  in  1  direction/target mispredicted; restore GHR

Behaviour:
- Storage is flop arrays: valid[set][way], tag, target[31:2], PHT counters, rr_ptr[set] (log2 WAYS bits), and ghr.
- PHT index: idx(pc,g) = pc[PHT_IDX_W+1:2] XOR zero-extended g.
- Reset (resetn=0 at a clk edge):
  - all valid bits, rr_ptr, and ghr are cleared;
  - every counter is set to weakly-not-taken, 2^(CNT_W-1)-1 (01 for CNT_W=2);
  - rsp_vld=0, rsp_hit=0, rsp_taken=0, rsp_way_vec=0, rsp_pc=0, rsp_next_pc=0, rsp_ghr=0.
  - A reset asserted mid-operation discards any in-flight request and update.
- Lookup, at the edge where req_vld=1: all rsp_* fields are registered from array state before that edge. There is no bypass of a same-cycle update.
  - hit_way[w] = valid & tag match. With multiple matches the lowest way wins (cannot occur under the allocation rule).
  - rsp_taken = hit & MSB of PHT[idx(req_pc,ghr)].
  - rsp_ghr = pre-shift ghr.
- rsp_vld=1 for exactly one cycle per request. When req_vld=0, rsp_vld=0 and the other rsp_* fields hold.
- GHR (one update per edge, in priority order):
  - upd_vld & upd_mispredict: ghr <= {upd_ghr[GHR_W-2:0], upd_taken};
  - else req_vld & hit: ghr <= {ghr[GHR_W-2:0], rsp_taken value being registered};
  - misses do not shift.
- PHT update on upd_vld: PHT[idx(upd_pc,upd_ghr)] increments if upd_taken, else decrements. It saturates at all-ones/zero and never wraps.
- BTB update, only on upd_vld & upd_taken:
  - upd_way_vec != 0: rewrite tag and target in that way of set(upd_pc); rr_ptr unchanged.
  - Else allocate: the lowest-index invalid way in the set. If the set is full, use way rr_ptr[set], then rr_ptr[set] <= (rr_ptr+1) mod WAYS.
  - The written way's valid bit is set.
  - Not-taken updates never allocate or modify the BTB.
- Simultaneous lookup and update to the same set or index: the lookup sees old state and the update takes effect at the same edge.
- Back-to-back requests are accepted every cycle; no stall, no backpressure.

Test Plan:
1. Reset, then req_pc=0x00001000 -> next cycle rsp_vld=1, rsp_hit=0, rsp_way_vec=0, rsp_taken=0, rsp_next_pc=0x00001004, rsp_ghr=0; ghr stays 0.
2. Allocate-and-hit:
   - upd {pc=0x1000, taken=1, target=0x2000, way_vec=0, ghr=0} -> way0 of set 0 valid, PHT[0] 01->10.
   - req 0x1000 -> rsp_hit=1, way_vec=01, rsp_taken=1, rsp_next_pc=0x2000; ghr becomes 0x01.
3. Replacement, from reset:
   - taken updates (way_vec=0) for pcs 0x1000, 0x2000, 0x3000 (all set 0) -> way0, way1, then way0 via rr_ptr=0; rr_ptr becomes 1.
   - Lookup 0x1000 misses; lookup 0x3000 hits way_vec=01.
4. Saturation, on PHT[0] from 01: four taken updates -> 11 (no wrap), then one not-taken -> 10, and the lookup still predicts taken.
5. Mispredict restore, ghr=0x01: upd_mispredict=1, upd_ghr=0x5A, upd_taken=0 -> ghr=0xB4. Repeat with a same-cycle hitting request -> ghr=0xB4 (restore wins) and that response's rsp_ghr=0x01.
6. Same-cycle conflict: req 0x1000 while upd writes a new target 0x4000 into its hit way -> the response shows the old target; the next request shows 0x4000.
